// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core: operands and op select in, registered result and flags out.
interface alu_core_if #(
  parameter int N = 32
);
  logic [N-1:0] in_A;
  logic [N-1:0] in_B;
  logic [3:0]   in_OP;
  logic         in_X;
  logic [N-1:0] out_RES;
  logic [4:0]   out_XNZVC;

  modport master (
    output in_A, in_B, in_OP, in_X,
    input  out_RES, out_XNZVC
  );

  modport slave (
    input  in_A, in_B, in_OP, in_X,
    output out_RES, out_XNZVC
  );
endinterface

// File: rtl/alu_core.sv
// Single-cycle ALU with 68k-style XNZVC flags; result and flags registered once per clock.
module alu_core #(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_core_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADDX = 4'd1,  OP_SUB  = 4'd2,  OP_SUBX = 4'd3,
    OP_NEG  = 4'd4,  OP_NEGX = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7,
    OP_EOR  = 4'd8,  OP_NOT  = 4'd9,  OP_CMP  = 4'd10, OP_MOVE = 4'd11,
    OP_ASX  = 4'd12, OP_LSX  = 4'd13, OP_ROX  = 4'd14, OP_ROXX = 4'd15
  } op_e;

  op_e          op;
  logic [N-1:0] a, b;
  logic [N:0]   sum, dif, neg;
  logic [5:0]   k;
  logic         left;
  logic [N-1:0] res, sh;
  logic [N:0]   rxv;
  logic         x_n, c_n, v_n, sc, sv;

  assign op   = op_e'(bus.in_OP);
  assign a    = bus.in_A;
  assign b    = bus.in_B;
  assign k    = b[5:0];
  assign left = b[7];

  // Operation decode and flag generation from the current inputs.
  // Shifts are unrolled as up to 63 single-bit steps so that large counts,
  // the last-bit-out carry and the ASL "MSB ever changed" overflow fall out
  // of the same step logic instead of separate special cases.
  always_comb begin
    res = '0;
    x_n = bus.in_X;
    c_n = 1'b0;
    v_n = 1'b0;
    sh  = a;
    rxv = {bus.in_X, a};
    sc  = 1'b0;
    sv  = 1'b0;
    sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, (op == OP_ADDX) & bus.in_X};
    dif = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, (op == OP_SUBX) & bus.in_X};
    neg = '0 - {1'b0, a} - {{N{1'b0}}, (op == OP_NEGX) & bus.in_X};
    case (op)
      OP_ADD, OP_ADDX: begin
        res = sum[N-1:0];
        c_n = sum[N];
        v_n = (a[N-1] == b[N-1]) && (res[N-1] != a[N-1]);
        x_n = c_n;
      end
      OP_SUB, OP_SUBX, OP_CMP: begin
        res = dif[N-1:0];
        c_n = dif[N];
        v_n = (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]);
        if (op != OP_CMP) x_n = c_n;
      end
      OP_NEG, OP_NEGX: begin
        res = neg[N-1:0];
        c_n = neg[N];
        v_n = a[N-1] & res[N-1];
        x_n = c_n;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_EOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_MOVE: res = b;
      OP_ASX, OP_LSX: begin
        for (int unsigned i = 0; i < 63; i++) begin
          if (i < 32'(k)) begin
            if (left) begin
              sc = sh[N-1];
              sh = {sh[N-2:0], 1'b0};
              if (op == OP_ASX && sh[N-1] != sc) sv = 1'b1;
            end else begin
              sc = sh[0];
              sh = {(op == OP_ASX) & sh[N-1], sh[N-1:1]};
            end
          end
        end
        res = sh;
        v_n = sv;
        if (k != 6'd0) begin
          c_n = sc;
          x_n = sc;
        end
      end
      OP_ROX: begin
        for (int unsigned i = 0; i < 63; i++) begin
          if (i < 32'(k)) begin
            if (left) sh = {sh[N-2:0], sh[N-1]};
            else      sh = {sh[0], sh[N-1:1]};
          end
        end
        res = sh;
        if (k != 6'd0) c_n = left ? sh[0] : sh[N-1];
      end
      OP_ROXX: begin
        for (int unsigned i = 0; i < 63; i++) begin
          if (i < 32'(k)) begin
            if (left) rxv = {rxv[N-1:0], rxv[N]};
            else      rxv = {rxv[0], rxv[N:1]};
          end
        end
        res = rxv[N-1:0];
        x_n = rxv[N];
        c_n = rxv[N];
      end
      default: ;
    endcase
  end

  // Output registers: the only state in the block; reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_RES   <= '0;
      bus.out_XNZVC <= '0;
    end else begin
      bus.out_RES   <= res;
      bus.out_XNZVC <= {x_n, res[N-1], (res == '0), v_n, c_n};
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core (N=32) with hand-computed results and XNZVC flags.
module tb_alu_core;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  alu_core_if #(.N(32)) bus ();

  alu_core #(.N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_f);
    tests_run++;
    assert (bus.out_RES === exp_res) else begin
      tests_failed++;
      $error("FAIL %s RES observed=%h expected=%h", tag, bus.out_RES, exp_res);
    end
    tests_run++;
    assert (bus.out_XNZVC === exp_f) else begin
      tests_failed++;
      $error("FAIL %s XNZVC observed=%b expected=%b", tag, bus.out_XNZVC, exp_f);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic x,
                      input logic [31:0] exp_res, input logic [4:0] exp_f);
    @(negedge clk);
    bus.in_OP = op;
    bus.in_A  = a;
    bus.in_B  = b;
    bus.in_X  = x;
    @(posedge clk);
    #1;
    check(tag, exp_res, exp_f);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    bus.in_OP = 4'd0;
    bus.in_A  = 32'h0000_0001;
    bus.in_B  = 32'h0000_0001;
    bus.in_X  = 1'b1;
    @(posedge clk);
    #1;
    check("reset", 32'h0, 5'b00000);
    @(negedge clk);
    reset = 1'b0;

    //     tag          op     A             B             X     RES           XNZVC
    step("add_ovf",    4'd0,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 5'b01010);
    step("sub_0m1",    4'd2,  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 5'b11001);
    step("addx_wrap",  4'd1,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 5'b10101);
    step("subx",       4'd3,  32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 5'b00000);
    step("neg_min",    4'd4,  32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 5'b11011);
    step("negx_0",     4'd5,  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 5'b11001);
    step("and",        4'd6,  32'h0000F0F0, 32'h0000FF00, 1'b1, 32'h0000F000, 5'b10000);
    step("or",         4'd7,  32'h0000F0F0, 32'h0F00000F, 1'b0, 32'h0F00F0FF, 5'b00000);
    step("eor_zero",   4'd8,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 5'b00100);
    step("not",        4'd9,  32'h00000000, 32'h12345678, 1'b0, 32'hFFFFFFFF, 5'b01000);
    step("cmp_keepx",  4'd10, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 5'b01001);
    step("move",       4'd11, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678, 5'b10000);
    step("rol4",       4'd14, 32'h000008FF, 32'h00000084, 1'b1, 32'h00008FF0, 5'b10000);
    step("ror1",       4'd14, 32'h000008FF, 32'h00000001, 1'b0, 32'h8000047F, 5'b01001);
    step("ror16",      4'd14, 32'h000008FF, 32'h00000010, 1'b0, 32'h08FF0000, 5'b00000);
    step("roxr1",      4'd15, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 5'b10101);
    step("roxl1",      4'd15, 32'h00000001, 32'h00000081, 1'b0, 32'h00000002, 5'b00000);
    step("lsl1_msb",   4'd13, 32'h80000000, 32'h00000081, 1'b0, 32'h00000000, 5'b10101);
    step("asl1_msb",   4'd12, 32'h80000000, 32'h00000081, 1'b0, 32'h00000000, 5'b10111);
    step("asr40",      4'd12, 32'h80000000, 32'h00000028, 1'b0, 32'hFFFFFFFF, 5'b11001);
    step("lsr40",      4'd13, 32'h80000000, 32'h00000028, 1'b1, 32'h00000000, 5'b00100);
    step("lsl32",      4'd13, 32'h00000001, 32'h000000A0, 1'b0, 32'h00000000, 5'b10101);
    step("asl_v01",    4'd12, 32'h40000000, 32'h00000081, 1'b0, 32'h80000000, 5'b01010);
    step("lsx_k0",     4'd13, 32'h00001234, 32'h00000080, 1'b1, 32'h00001234, 5'b10000);
    step("rox_k0",     4'd14, 32'h00001234, 32'h00000000, 1'b1, 32'h00001234, 5'b10000);
    step("roxx_k0",    4'd15, 32'h00001234, 32'h00000080, 1'b1, 32'h00001234, 5'b10001);
    step("lsr_hib",    4'd13, 32'h00001234, 32'hFFFFFF44, 1'b1, 32'h00000123, 5'b00000);
    step("roxr33",     4'd15, 32'h00000001, 32'h00000021, 1'b1, 32'h00000001, 5'b10001);

    // Reset pulse in the middle of back-to-back operations.
    @(negedge clk);
    reset     = 1'b1;
    bus.in_OP = 4'd0;
    bus.in_A  = 32'h00000001;
    bus.in_B  = 32'h00000001;
    bus.in_X  = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 32'h0, 5'b00000);
    @(negedge clk);
    reset = 1'b0;
    bus.in_A = 32'h00000002;
    bus.in_B = 32'h00000003;
    bus.in_X = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", 32'h00000005, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width; legal N >= 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_A  input  N  first operand; also the value shifted/rotated.
REQ-005 SHALL have port in_B  input  N  second operand; for shift ops B[5:0] = count, B[7] = direction (1 left, 0 right).
REQ-006 SHALL have port in_OP  input  4  operation select.
REQ-007 SHALL have port in_X  input  1  current extend flag, used by ADDX/SUBX/NEGX/ROXx.
REQ-008 SHALL have port out_RES  output  N  registered result.
REQ-009 SHALL have port out_XNZVC  output  5  registered flags; bit4 X, bit3 N, bit2 Z, bit1 V, bit0 C.

Function
REQ-010 SHALL compute result and flags combinationally from current inputs and register both on every rising clk edge; latency exactly 1 cycle, new operation accepted every cycle, no handshake.
REQ-011 SHALL decode in_OP: 0 ADD, 1 ADDX, 2 SUB, 3 SUBX, 4 NEG, 5 NEGX, 6 AND, 7 OR, 8 EOR, 9 NOT, 10 CMP, 11 MOVE, 12 ASx, 13 LSx, 14 ROx, 15 ROXx.
REQ-012 SHALL compute ADD A+B, ADDX A+B+X, SUB A-B, SUBX A-B-X, NEG 0-A, NEGX 0-A-X, CMP A-B, all modulo 2^N.
REQ-013 SHALL, for arithmetic ops, set C = carry out (add) or borrow (sub/neg/cmp), V = signed overflow, X = C except CMP where X = in_X.
REQ-014 SHALL compute AND A&B, OR A|B, EOR A^B, NOT ~A, MOVE B; V=0, C=0, X=in_X.
REQ-015 SHALL for all ops set N = RES[N-1] and Z = (RES == 0).
REQ-016 SHALL take shift count k = B[5:0] (0..63), independent of N.
REQ-017 SHALL ASL fill zeros; V=1 if the MSB changes at any point during the k steps; ASR fill with A[N-1], V=0.
REQ-018 SHALL LSL/LSR fill zeros; k >= N gives 0 (ASR with k >= N gives all copies of sign).
REQ-019 SHALL, for ASx/LSx with k>0, set C = X = last bit shifted out (0 if k > N, except ASR: sign bit).
REQ-020 SHALL ROx rotate A by k mod N; C = last bit rotated out (k>0: ROL -> RES[0], ROR -> RES[N-1]); V=0; X=in_X.
REQ-021 SHALL ROXx rotate the N+1-bit value {X,A} by k mod (N+1); C = X = final extend bit; V=0.
REQ-022 SHALL for any shift with k=0 output RES=A, V=0, X=in_X, C=0 (ROXx: C=in_X).
REQ-023 SHALL behave identically for any in_B bits outside [7] and [5:0] under shift ops.

Reset
REQ-024 SHALL, when reset is high at a rising edge, load out_RES=0 and out_XNZVC=0, overriding any operation.
REQ-025 SHALL resume normal registered operation on the first rising edge with reset low; reset mid-stream discards the in-flight result.
REQ-026 SHALL hold no state other than the two output registers.

Verification
REQ-027 ROx, A=0x000008FF, B=0x84 -> next cycle RES=0x00008FF0, XNZVC X=in_X, N=0,Z=0,V=0,C=0.
REQ-028 ROx, A=0x000008FF, B=0x01 -> RES=0x8000047F, N=1, C=1; B=0x10 -> RES=0x08FF0000, C=0.
REQ-029 ROXx, A=0x00000001, in_X=0, B=0x01 -> RES=0, X=1, C=1, Z=1; B=0x81 -> RES=0x00000002, X=0, C=0.
REQ-030 ADD 0x7FFFFFFF+0x00000001 -> RES=0x80000000, N=1, V=1, C=0, X=0; SUB 0-1 -> RES=0xFFFFFFFF, X=1, N=1, C=1.
REQ-031 LSx, A=0x80000000, B=0x81 -> RES=0, Z=1, C=X=1; ASx same -> also V=1.
REQ-032 Reset asserted for one edge during back-to-back ops -> outputs 0 that cycle, correct result on following edge.
